// File: rtl/bp_cfg_fwd_arbiter.sv
// Round-robin arbiter sharing one BedRock mem_fwd/mem_rev config channel among
// num_req_p requesters; an in-order tag queue routes each response home.
module bp_cfg_fwd_arbiter #(
  parameter int num_req_p               = 2,
  parameter int tag_els_p               = 4,
  // Widths normally derived from bp_params_p (e_bp_default_cfg)
  parameter int mem_fwd_header_width_lp = 66,
  parameter int mem_rev_header_width_lp = 66,
  parameter int bedrock_fill_width_p    = 64
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,

  input  logic [num_req_p*mem_fwd_header_width_lp-1:0]  req_fwd_header_i,
  input  logic [num_req_p*bedrock_fill_width_p-1:0]     req_fwd_data_i,
  input  logic [num_req_p-1:0]                          req_fwd_v_i,
  output logic [num_req_p-1:0]                          req_fwd_ready_and_o,

  output logic [mem_fwd_header_width_lp-1:0]            mem_fwd_header_o,
  output logic [bedrock_fill_width_p-1:0]               mem_fwd_data_o,
  output logic                                          mem_fwd_v_o,
  input  logic                                          mem_fwd_ready_and_i,

  input  logic [mem_rev_header_width_lp-1:0]            mem_rev_header_i,
  input  logic [bedrock_fill_width_p-1:0]               mem_rev_data_i,
  input  logic                                          mem_rev_v_i,
  output logic                                          mem_rev_ready_and_o,

  output logic [mem_rev_header_width_lp-1:0]            req_rev_header_o,
  output logic [bedrock_fill_width_p-1:0]               req_rev_data_o,
  output logic [num_req_p-1:0]                          req_rev_v_o,
  input  logic [num_req_p-1:0]                          req_rev_ready_and_i,

  output logic                                          error_o
);

  localparam int          req_id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int          ptr_width_lp    = (tag_els_p > 1) ? $clog2(tag_els_p) : 1;
  localparam int          cnt_width_lp    = $clog2(tag_els_p + 1);
  localparam int unsigned num_req_lp      = num_req_p;

  logic [num_req_p-1:0][mem_fwd_header_width_lp-1:0] hdr_arr;
  logic [num_req_p-1:0][bedrock_fill_width_p-1:0]    data_arr;

  logic [req_id_width_lp-1:0] last_grant_r, lock_id_r, grant_id, head_id;
  logic                       lock_r, error_r;
  logic [req_id_width_lp-1:0] tag_mem_r [tag_els_p];
  logic [ptr_width_lp-1:0]    rptr_r, wptr_r;
  logic [cnt_width_lp-1:0]    tag_cnt_r;

  logic tag_full, tag_empty, fwd_hs, rev_hs, stray;
  logic found;
  int unsigned idx;

  assign hdr_arr  = req_fwd_header_i;
  assign data_arr = req_fwd_data_i;

  assign tag_full  = (tag_cnt_r == cnt_width_lp'(tag_els_p));
  assign tag_empty = (tag_cnt_r == '0);
  assign head_id   = tag_mem_r[rptr_r];

  // A pending-but-unaccepted grant is pinned so the downstream beat stays stable
  always_comb begin
    found    = 1'b0;
    idx      = 0;
    grant_id = req_id_width_lp'((32'(last_grant_r) + 1) % num_req_lp);
    if (lock_r) begin
      grant_id = lock_id_r;
    end else begin
      for (int unsigned i = 1; i <= num_req_lp; i++) begin
        idx = (32'(last_grant_r) + i) % num_req_lp;
        if (!found && req_fwd_v_i[idx]) begin
          grant_id = req_id_width_lp'(idx);
          found    = 1'b1;
        end
      end
    end
  end

  assign mem_fwd_header_o = hdr_arr[grant_id];
  assign mem_fwd_data_o   = data_arr[grant_id];
  assign mem_fwd_v_o      = reset_i & (|req_fwd_v_i) & ~tag_full;
  assign fwd_hs           = mem_fwd_v_o & mem_fwd_ready_and_i;

  always_comb begin
    req_fwd_ready_and_o = '0;
    if (reset_i && mem_fwd_ready_and_i && !tag_full)
      req_fwd_ready_and_o[grant_id] = 1'b1;
  end

  // With nothing outstanding a response is swallowed rather than stalling the endpoint
  always_comb begin
    req_rev_v_o         = '0;
    mem_rev_ready_and_o = 1'b0;
    if (reset_i) begin
      if (tag_empty) begin
        mem_rev_ready_and_o = 1'b1;
      end else begin
        mem_rev_ready_and_o  = req_rev_ready_and_i[head_id];
        req_rev_v_o[head_id] = mem_rev_v_i;
      end
    end
  end

  assign req_rev_header_o = mem_rev_header_i;
  assign req_rev_data_o   = mem_rev_data_i;
  assign rev_hs           = mem_rev_v_i & mem_rev_ready_and_o & ~tag_empty;
  assign stray            = reset_i & mem_rev_v_i & tag_empty;
  assign error_o          = error_r;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      last_grant_r <= req_id_width_lp'(num_req_p - 1);
      lock_r       <= 1'b0;
      lock_id_r    <= '0;
      rptr_r       <= '0;
      wptr_r       <= '0;
      tag_cnt_r    <= '0;
      error_r      <= 1'b0;
    end else begin
      if (fwd_hs) begin
        last_grant_r <= grant_id;
        lock_r       <= 1'b0;
        wptr_r       <= (wptr_r == ptr_width_lp'(tag_els_p - 1)) ? '0 : wptr_r + 1'b1;
      end else if (mem_fwd_v_o) begin
        lock_r    <= 1'b1;
        lock_id_r <= grant_id;
      end
      if (rev_hs)
        rptr_r <= (rptr_r == ptr_width_lp'(tag_els_p - 1)) ? '0 : rptr_r + 1'b1;
      case ({fwd_hs, rev_hs})
        2'b10:   tag_cnt_r <= tag_cnt_r + 1'b1;
        2'b01:   tag_cnt_r <= tag_cnt_r - 1'b1;
        default: tag_cnt_r <= tag_cnt_r;
      endcase
      if (stray)
        error_r <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fwd_hs)
      tag_mem_r[wptr_r] <= grant_id;
  end

endmodule

// File: tb/tb_bp_cfg_fwd_arbiter.sv
// Scoreboard bench for bp_cfg_fwd_arbiter: three requesters, four-deep tag queue.
module tb_bp_cfg_fwd_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [N-1:0][W-1:0] hdr_in, dat_in;
  logic [N-1:0]      req_fwd_v_i;
  logic [N-1:0]      req_fwd_ready_and_o;
  logic [W-1:0]      mem_fwd_header_o, mem_fwd_data_o;
  logic              mem_fwd_v_o;
  logic              mem_fwd_ready_and_i;
  logic [W-1:0]      mem_rev_header_i, mem_rev_data_i;
  logic              mem_rev_v_i;
  logic              mem_rev_ready_and_o;
  logic [W-1:0]      req_rev_header_o, req_rev_data_o;
  logic [N-1:0]      req_rev_v_o;
  logic [N-1:0]      req_rev_ready_and_i;
  logic              error_o;

  bp_cfg_fwd_arbiter #(
    .num_req_p(N),
    .tag_els_p(4),
    .mem_fwd_header_width_lp(W),
    .mem_rev_header_width_lp(W),
    .bedrock_fill_width_p(W)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .req_fwd_header_i(hdr_in),
    .req_fwd_data_i(dat_in),
    .req_fwd_v_i(req_fwd_v_i),
    .req_fwd_ready_and_o(req_fwd_ready_and_o),
    .mem_fwd_header_o(mem_fwd_header_o),
    .mem_fwd_data_o(mem_fwd_data_o),
    .mem_fwd_v_o(mem_fwd_v_o),
    .mem_fwd_ready_and_i(mem_fwd_ready_and_i),
    .mem_rev_header_i(mem_rev_header_i),
    .mem_rev_data_i(mem_rev_data_i),
    .mem_rev_v_i(mem_rev_v_i),
    .mem_rev_ready_and_o(mem_rev_ready_and_o),
    .req_rev_header_o(req_rev_header_o),
    .req_rev_data_o(req_rev_data_o),
    .req_rev_v_o(req_rev_v_o),
    .req_rev_ready_and_i(req_rev_ready_and_i),
    .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [W-1:0] hdr; logic [W-1:0] dat; } fwd_t;
  typedef struct { logic [N-1:0] rv; logic [W-1:0] hdr; logic [W-1:0] dat; } rev_t;
  typedef struct { string name; logic [8:0] exp; logic [8:0] mask; logic hchk; logic [W-1:0] hdr; } probe_t;

  fwd_t   fwd_q[$];
  rev_t   rev_q[$];
  probe_t probe_q[$];

  int  n_cmp = 0;
  int  n_err = 0;
  int  cycles = 0;
  logic done = 1'b0;

  // status vector: {mem_fwd_v, req_fwd_ready[2:0], mem_rev_ready, req_rev_v[2:0], error}
  localparam logic [8:0] FULL = 9'h1FF;
  localparam logic [8:0] NOFR = 9'h11F;

  function automatic logic [W-1:0] hdr_of(int i);
    return 32'h0020_0008 | (32'(i) << 28);
  endfunction

  function automatic logic [W-1:0] dat_of(int i);
    return 32'h5 + 32'(i) * 32'h10;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic exp_fwd(int i);
    fwd_t f;
    f.hdr = hdr_of(i);
    f.dat = dat_of(i);
    fwd_q.push_back(f);
  endtask

  task automatic probe(string n, logic fv, logic [2:0] fr, logic rr, logic [2:0] rv,
                       logic e, logic [8:0] mask, logic hchk, logic [W-1:0] h);
    probe_t p;
    p.name = n;
    p.exp  = {fv, fr, rr, rv, e};
    p.mask = mask;
    p.hchk = hchk;
    p.hdr  = h;
    probe_q.push_back(p);
  endtask

  task automatic respond(logic [2:0] rv, logic [W-1:0] h);
    rev_t r;
    mem_rev_v_i      = 1'b1;
    mem_rev_header_i = h;
    mem_rev_data_i   = ~h;
    r.rv  = rv;
    r.hdr = h;
    r.dat = ~h;
    rev_q.push_back(r);
    tick();
    mem_rev_v_i = 1'b0;
  endtask

  // Monitor: all comparisons happen here, mid-cycle
  always @(negedge clk_i) begin
    logic [8:0] act;
    cycles++;
    if (mem_fwd_v_o && mem_fwd_ready_and_i) begin
      n_cmp++;
      if (fwd_q.size() == 0) begin
        n_err++;
        $display("FAIL fwd_unexpected: got hdr %h, required no handshake", mem_fwd_header_o);
      end else begin
        fwd_t f;
        f = fwd_q.pop_front();
        if (mem_fwd_header_o !== f.hdr || mem_fwd_data_o !== f.dat) begin
          n_err++;
          $display("FAIL fwd_beat: got %h/%h required %h/%h", mem_fwd_header_o, mem_fwd_data_o, f.hdr, f.dat);
        end
      end
    end
    if (mem_rev_v_i && mem_rev_ready_and_o) begin
      n_cmp++;
      if (rev_q.size() == 0) begin
        n_err++;
        $display("FAIL rev_unexpected: got rv %b, required no handshake", req_rev_v_o);
      end else begin
        rev_t r;
        r = rev_q.pop_front();
        if (req_rev_v_o !== r.rv || req_rev_header_o !== r.hdr || req_rev_data_o !== r.dat) begin
          n_err++;
          $display("FAIL rev_route: got %b %h/%h required %b %h/%h", req_rev_v_o, req_rev_header_o,
                   req_rev_data_o, r.rv, r.hdr, r.dat);
        end
      end
    end
    while (probe_q.size() > 0) begin
      probe_t p;
      p = probe_q.pop_front();
      act = {mem_fwd_v_o, req_fwd_ready_and_o, mem_rev_ready_and_o, req_rev_v_o, error_o};
      n_cmp++;
      if ((act & p.mask) !== (p.exp & p.mask)) begin
        n_err++;
        $display("FAIL %s: got %b required %b (mask %b)", p.name, act, p.exp, p.mask);
      end
      if (p.hchk) begin
        n_cmp++;
        if (mem_fwd_header_o !== p.hdr) begin
          n_err++;
          $display("FAIL %s_hdr: got %h required %h", p.name, mem_fwd_header_o, p.hdr);
        end
      end
    end
    if (cycles > 2000) begin
      $display("FAIL timeout: got %0d cycles required under 2000", cycles);
      $fatal(1, "bench did not complete");
    end
    if (done) begin
      n_cmp++;
      if (fwd_q.size() != 0 || rev_q.size() != 0) begin
        n_err++;
        $display("FAIL leftover: got %0d fwd / %0d rev pending required 0 / 0", fwd_q.size(), rev_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      hdr_in[i] = hdr_of(i);
      dat_in[i] = dat_of(i);
    end
    // Reset held with everything active: outputs must stay quiet
    reset_i             = 1'b0;
    req_fwd_v_i         = 3'b111;
    mem_fwd_ready_and_i = 1'b1;
    mem_rev_v_i         = 1'b1;
    mem_rev_header_i    = '0;
    mem_rev_data_i      = '0;
    req_rev_ready_and_i = 3'b111;
    probe("reset_state", 0, 3'b000, 0, 3'b000, 0, FULL, 0, '0);
    tick();
    tick();
    req_fwd_v_i = '0;
    mem_rev_v_i = 1'b0;
    reset_i     = 1'b1;

    // Single requester
    req_fwd_v_i = 3'b001;
    exp_fwd(0);
    probe("single_issue", 1, 3'b001, 1, 3'b000, 0, FULL, 1, hdr_of(0));
    tick();
    req_fwd_v_i = '0;
    tick();
    tick();
    probe("single_resp", 0, 3'b000, 1, 3'b001, 0, NOFR, 0, '0);
    respond(3'b001, 32'hC0DE_0001);

    // Two outstanding, then asynchronous reset
    req_fwd_v_i = 3'b110;
    exp_fwd(1);
    exp_fwd(2);
    tick();
    tick();
    req_fwd_v_i         = 3'b111;
    mem_rev_v_i         = 1'b1;
    mem_rev_header_i    = 32'hC0DE_0002;
    mem_rev_data_i      = ~32'hC0DE_0002;
    reset_i             = 1'b0;
    probe("reset_midop", 0, 3'b000, 0, 3'b000, 0, FULL, 0, '0);
    tick();
    reset_i = 1'b1;

    // First cycle after release: req0 wins, the response is stray
    begin
      rev_t r;
      r.rv = 3'b000; r.hdr = 32'hC0DE_0002; r.dat = ~32'hC0DE_0002;
      rev_q.push_back(r);
    end
    exp_fwd(0);
    probe("stray_first", 1, 3'b001, 1, 3'b000, 0, FULL, 1, hdr_of(0));
    tick();
    mem_rev_v_i = 1'b0;
    exp_fwd(1);
    probe("rr_1", 1, 3'b010, 1, 3'b000, 1, FULL, 1, hdr_of(1));
    tick();
    exp_fwd(2);
    tick();
    req_fwd_v_i = '0;
    respond(3'b001, 32'hC0DE_0010);
    respond(3'b010, 32'hC0DE_0011);
    respond(3'b100, 32'hC0DE_0012);
    req_fwd_v_i = 3'b111;
    exp_fwd(0);
    exp_fwd(1);
    exp_fwd(2);
    tick();
    tick();
    tick();
    req_fwd_v_i = '0;
    mem_rev_v_i         = 1'b1;
    req_rev_ready_and_i = 3'b110;
    probe("rev_stall", 0, 3'b000, 0, 3'b001, 1, NOFR, 0, '0);
    tick();
    req_rev_ready_and_i = 3'b111;
    respond(3'b001, 32'hC0DE_0020);
    respond(3'b010, 32'hC0DE_0021);
    respond(3'b100, 32'hC0DE_0022);

    // Backpressure lock: req1 pending, req0 arrives later
    mem_fwd_ready_and_i = 1'b0;
    req_fwd_v_i = 3'b010;
    probe("lock_c1", 1, 3'b000, 1, 3'b000, 1, FULL, 1, hdr_of(1));
    tick();
    req_fwd_v_i = 3'b011;
    probe("lock_c2", 1, 3'b000, 1, 3'b000, 1, FULL, 1, hdr_of(1));
    tick();
    probe("lock_c3", 1, 3'b000, 1, 3'b000, 1, FULL, 1, hdr_of(1));
    tick();
    probe("lock_c4", 1, 3'b000, 1, 3'b000, 1, FULL, 1, hdr_of(1));
    tick();
    mem_fwd_ready_and_i = 1'b1;
    exp_fwd(1);
    probe("lock_accept", 1, 3'b010, 1, 3'b000, 1, FULL, 1, hdr_of(1));
    tick();
    req_fwd_v_i = 3'b001;
    exp_fwd(0);
    tick();
    req_fwd_v_i = '0;
    respond(3'b010, 32'hC0DE_0030);
    respond(3'b001, 32'hC0DE_0031);

    // Queue full
    req_fwd_v_i = 3'b001;
    for (int i = 0; i < 4; i++) begin
      exp_fwd(0);
      tick();
    end
    probe("full_block", 0, 3'b000, 1, 3'b000, 1, FULL, 0, '0);
    tick();
    probe("full_pop_same_cycle", 0, 3'b000, 1, 3'b001, 1, FULL, 0, '0);
    respond(3'b001, 32'hC0DE_0040);
    exp_fwd(0);
    probe("full_released", 1, 3'b001, 1, 3'b000, 1, FULL, 1, hdr_of(0));
    tick();
    req_fwd_v_i = '0;
    for (int i = 0; i < 4; i++)
      respond(3'b001, 32'hC0DE_0050 + 32'(i));

    // Reset clears the sticky error
    reset_i = 1'b0;
    probe("reset_clears_error", 0, 3'b000, 0, 3'b000, 0, FULL, 0, '0);
    tick();
    reset_i = 1'b1;
    probe("post_reset_idle", 0, 3'b000, 1, 3'b000, 0, NOFR, 0, '0);
    tick();
    done = 1'b1;
  end

endmodule
